// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_ram block.
package sync_fifo_pkg;

    localparam int DEF_B  = 8;
    localparam int DEF_W  = 4;
    localparam int MAX_CW = 13;

    typedef logic [MAX_CW-1:0] cnt_t;

    function automatic int fifo_depth(input int w);
        return 1 << w;
    endfunction

    // Simultaneous accepted read and write leave occupancy unchanged.
    function automatic cnt_t next_count(input cnt_t c, input logic wr_acc, input logic rd_acc);
        cnt_t n;
        n = c;
        if (wr_acc && !rd_acc)
            n = c + cnt_t'(1);
        else if (rd_acc && !wr_acc)
            n = c - cnt_t'(1);
        return n;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM, B x 2^W, with a registered and enabled read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int B = DEF_B,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [W-1:0] w_addr,
    input  logic [B-1:0] w_data,
    input  logic         re,
    input  logic [W-1:0] r_addr,
    output logic [B-1:0] r_data
);

    localparam int DEPTH = fifo_depth(W);

    logic [B-1:0] mem [DEPTH];
    logic [B-1:0] r_data_reg;

    // Storage has no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[w_addr] <= w_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_data_reg <= '0;
        else if (re)
            r_data_reg <= mem[r_addr];
    end

    assign r_data = r_data_reg;

endmodule

// File: rtl/sync_fifo_ram.sv
// Synchronous FIFO on an inferred dual-port RAM with count, thresholds and
// optional sticky error flags (enabled by defining SYNC_FIFO_ERR_EN).
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int B        = DEF_B,
    parameter int W        = DEF_W,
    parameter int AF_LEVEL = (1 << W) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    input  logic         clr_err,
    output logic         overflow,
    output logic         underflow
);

    localparam int       DEPTH   = fifo_depth(W);
    localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);
    localparam logic [W:0] AF_C    = (W+1)'(AF_LEVEL);
    localparam logic [W:0] AE_C    = (W+1)'(AE_LEVEL);

    logic [W-1:0] w_ptr_reg, r_ptr_reg;
    logic [W:0]   count_reg, count_next;
    logic         empty_reg, full_reg, ae_reg, af_reg;
    logic         wr_acc, rd_acc;

    // Full+wr+rd admits only the read, empty+wr+rd only the write, so the
    // RAM never sees a same-address read and write in one cycle.
    assign wr_acc     = wr & ~full_reg;
    assign rd_acc     = rd & ~empty_reg;
    assign count_next = (W+1)'(next_count(cnt_t'(count_reg), wr_acc, rd_acc));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_reg <= '0;
            r_ptr_reg <= '0;
            count_reg <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
            ae_reg    <= 1'b1;
            af_reg    <= (AF_LEVEL == 0);
        end else begin
            if (wr_acc)
                w_ptr_reg <= w_ptr_reg + 1'b1;
            if (rd_acc)
                r_ptr_reg <= r_ptr_reg + 1'b1;
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == DEPTH_C);
            ae_reg    <= (count_next <= AE_C);
            af_reg    <= (count_next >= AF_C);
        end
    end

    sync_fifo_mem #(.B(B), .W(W)) u_mem (
        .clk    (clk),
        .reset  (reset),
        .we     (wr_acc),
        .w_addr (w_ptr_reg),
        .w_data (w_data),
        .re     (rd_acc),
        .r_addr (r_ptr_reg),
        .r_data (r_data)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_reg, underflow_reg;

    // Clear wins over a set arriving on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clr_err) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr & full_reg)
                overflow_reg <= 1'b1;
            if (rd & empty_reg)
                underflow_reg <= 1'b1;
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

    assign count        = count_reg;
    assign empty        = empty_reg;
    assign full         = full_reg;
    assign almost_empty = ae_reg;
    assign almost_full  = af_reg;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Scoreboard bench for sync_fifo_ram (B=8, W=4, AF=14, AE=2).
module tb_sync_fifo_ram;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [7:0] w_data = '0;
    logic [7:0] r_data;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0] count;

    int         vec_cnt = 0;
    int         err_cnt = 0;

    logic [7:0] sb[$];
    int         mcount = 0;
    logic [7:0] exp_rdata = '0;
    logic       exp_ovf = 1'b0, exp_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_ram #(.B(8), .W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // One clock of stimulus; scoreboard updated from the pre-edge model state.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic wa, ra;
        wr = w; w_data = d; rd = r; clr_err = c;
        @(posedge clk); #1;
        wa = w && (mcount < 16);
        ra = r && (mcount > 0);
`ifdef SYNC_FIFO_ERR_EN
        if (c) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            if (w && mcount == 16) exp_ovf = 1'b1;
            if (r && mcount == 0)  exp_unf = 1'b1;
        end
`endif
        if (ra) exp_rdata = sb.pop_front();
        if (wa) sb.push_back(d);
        mcount = mcount + int'(wa) - int'(ra);
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        $display("txn wr=%0b d=%02h rd=%0b clr=%0b -> count=%0d r_data=%02h", w, d, r, c, count, r_data);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h56, 1'b0, 1'b0);
        vec_cnt++;
        if (count !== 5'd5 || r_data !== 8'h51) begin
            err_cnt++;
            $display("FAIL pre_reset: count=%0d r_data=%02h, required 5 / 51", count, r_data);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete(); mcount = 0; exp_rdata = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
        vec_cnt++;
        if ({count, empty, almost_empty, full, almost_full, r_data, overflow, underflow}
            !== {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset_state: count=%0d e=%0b ae=%0b f=%0b af=%0b r=%02h ov=%0b un=%0b, required 0 1 1 0 0 00 0 0",
                     count, empty, almost_empty, full, almost_full, r_data, overflow, underflow);
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 8'(k - 1), 1'b0, 1'b0);
            vec_cnt++;
            if (count !== 5'(mcount) || almost_full !== (k >= 14) || full !== (k == 16) || empty !== 1'b0
                || almost_empty !== (k <= 2)) begin
                err_cnt++;
                $display("FAIL fill_%0d: count=%0d af=%0b f=%0b e=%0b ae=%0b, required count=%0d af=%0b f=%0b e=0 ae=%0b",
                         k, count, almost_full, full, empty, almost_empty, mcount, k >= 14, k == 16, k <= 2);
            end
        end
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        vec_cnt++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== exp_ovf) begin
            err_cnt++;
            $display("FAIL overflow_write: count=%0d full=%0b ov=%0b, required 16 1 %0b", count, full, overflow, exp_ovf);
        end
    endtask

    task automatic test_drain();
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            vec_cnt++;
            if (r_data !== exp_rdata || count !== 5'(mcount) || empty !== (k == 16)) begin
                err_cnt++;
                $display("FAIL drain_%0d: r_data=%02h count=%0d e=%0b, required %02h %0d %0b",
                         k, r_data, count, empty, exp_rdata, mcount, k == 16);
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vec_cnt++;
        if (r_data !== 8'h0F || exp_rdata !== 8'h0F || underflow !== exp_unf || count !== 5'd0) begin
            err_cnt++;
            $display("FAIL underflow_read: r_data=%02h un=%0b count=%0d, required 0f %0b 0", r_data, underflow, count, exp_unf);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        d = 8'h20;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, d, 1'b0, 1'b0);
            d++;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, d, 1'b1, 1'b0);
            vec_cnt++;
            if (count !== 5'd3 || r_data !== exp_rdata || r_data !== d - 8'd3 || overflow !== exp_ovf || underflow !== exp_unf) begin
                err_cnt++;
                $display("FAIL wrap_%0d: count=%0d r_data=%02h ov=%0b un=%0b, required 3 %02h %0b %0b",
                         i, count, r_data, overflow, underflow, exp_rdata, exp_ovf, exp_unf);
            end
            d++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            vec_cnt++;
            if (r_data !== exp_rdata) begin
                err_cnt++;
                $display("FAIL wrap_tail_%0d: r_data=%02h, required %02h", i, r_data, exp_rdata);
            end
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        vec_cnt++;
        if (count !== 5'd15 || r_data !== 8'h80 || full !== 1'b0) begin
            err_cnt++;
            $display("FAIL full_wr_rd: count=%0d r_data=%02h full=%0b, required 15 80 0", count, r_data, full);
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            vec_cnt++;
            if (r_data !== exp_rdata || r_data === 8'hEE) begin
                err_cnt++;
                $display("FAIL full_drain_%0d: r_data=%02h, required %02h", i, r_data, exp_rdata);
            end
        end
        step(1'b1, 8'h77, 1'b1, 1'b0);
        vec_cnt++;
        if (count !== 5'd1 || r_data !== 8'h8F || empty !== 1'b0) begin
            err_cnt++;
            $display("FAIL empty_wr_rd: count=%0d r_data=%02h empty=%0b, required 1 8f 0", count, r_data, empty);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vec_cnt++;
        if (r_data !== 8'h77 || empty !== 1'b1) begin
            err_cnt++;
            $display("FAIL empty_wr_rd_data: r_data=%02h empty=%0b, required 77 1", r_data, empty);
        end
    endtask

    task automatic test_err_flags();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        vec_cnt++;
        if (overflow !== 1'b0 || exp_ovf !== 1'b0) begin
            err_cnt++;
            $display("FAIL clr_priority_ovf: ov=%0b, required 0", overflow);
        end
        step(1'b1, 8'h99, 1'b0, 1'b0);
        vec_cnt++;
        if (overflow !== exp_ovf || count !== 5'd16) begin
            err_cnt++;
            $display("FAIL ovf_set: ov=%0b count=%0d, required %0b 16", overflow, count, exp_ovf);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        vec_cnt++;
        if (overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL ovf_clear: ov=%0b, required 0", overflow);
        end
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        vec_cnt++;
        if (underflow !== 1'b0 || r_data !== 8'h0F) begin
            err_cnt++;
            $display("FAIL clr_priority_unf: un=%0b r_data=%02h, required 0 0f", underflow, r_data);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vec_cnt++;
        if (underflow !== exp_unf || overflow !== exp_ovf) begin
            err_cnt++;
            $display("FAIL unf_set: un=%0b ov=%0b, required %0b %0b", underflow, overflow, exp_unf, exp_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_boundary();
        test_err_flags();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
